// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU types and constants for the DIV/MOD resource.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam int DIV_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // Iteration counter wide enough to hold the operand width itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage
`default_nettype wire

// File: rtl/trial_sub_nb.sv
`default_nettype none
// ============================================================================
// Module   : trial_sub_nb
// Brief    : N-bit ripple subtractor (a - b) built from full-adder cells.
// Revision : 1.0
// ============================================================================
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module trial_sub_nb #(
    parameter int N = 5
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_diff,
    output logic         o_borrow
);
    logic [N:0] w_carry;

    // a + ~b + 1; a missing final carry means b > a.
    assign w_carry[0] = 1'b1;

    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        full_adder u_fa (
            .i_a (i_a[gi]),
            .i_b (~i_b[gi]),
            .i_c (w_carry[gi]),
            .o_s (o_diff[gi]),
            .o_c (w_carry[gi+1])
        );
    end

    assign o_borrow = ~w_carry[N];
endmodule
`default_nettype wire

// File: rtl/divider_4b_seq.sv
`default_nettype none
// ============================================================================
// Module   : divider_4b_seq
// Brief    : Sequential unsigned restoring divider, one trial subtract per cycle.
// Revision : 1.0
// ============================================================================
module divider_4b_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = cnt_width(WIDTH);

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dvsr;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;

    logic [WIDTH:0]   w_p_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_p_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_borrow;
    logic             w_last;
    logic             w_unused_pmsb;

    assign w_p_shift = {r_p, r_q[WIDTH-1]};

    trial_sub_nb #(
        .N (WIDTH + 1)
    ) u_trial_sub (
        .i_a      (w_p_shift),
        .i_b      ({1'b0, r_dvsr}),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    // The restored remainder is always below the divisor, so its MSB is zero.
    assign w_p_nxt       = w_borrow ? w_p_shift : w_diff;
    assign w_unused_pmsb = w_p_nxt[WIDTH];
    assign w_q_nxt       = {r_q[WIDTH-2:0], ~w_borrow};
    assign w_last        = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = (divisor == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_p     <= '0;
            r_q     <= '0;
            r_dvsr  <= '0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            r_quot <= '1;
                            r_rem  <= dividend;
                            r_dbz  <= 1'b1;
                        end else begin
                            r_q    <= dividend;
                            r_p    <= '0;
                            r_dvsr <= divisor;
                            r_cnt  <= '0;
                            r_dbz  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    r_p   <= w_p_nxt[WIDTH-1:0];
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_quot <= w_q_nxt;
                        r_rem  <= w_p_nxt[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_divider_4b_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_4b_seq
// Brief    : Directed self-checking bench for divider_4b_seq.
// Revision : 1.0
// ============================================================================
module tb_divider_4b_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    divider_4b_seq #(
        .WIDTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start is driven after an edge (edge 0); lat is the edge count after which done is seen.
    task automatic run_div(input string tag, input logic [3:0] dd, input logic [3:0] dv,
                           input logic [3:0] eq, input logic [3:0] er, input logic edbz,
                           input int elat, input bit inject);
        logic [15:0] busy_seen;
        logic [15:0] busy_exp;
        int          lat;
        tick();
        check({tag, " done low before start"}, done, 0);
        dividend  = dd;
        divisor   = dv;
        start     = 1'b1;
        busy_seen = '0;
        lat       = 0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (n == 1) begin
                start    = 1'b0;
                dividend = ~dd;
                divisor  = ~dv;
                if (inject) begin
                    start    = 1'b1;
                    dividend = 4'd15;
                    divisor  = 4'd15;
                end
            end
            if (n == 2) start = 1'b0;
            busy_seen[n] = busy;
            if (done) begin
                lat = n;
                break;
            end
        end
        busy_exp = (elat <= 1) ? 16'd0 : 16'((1 << elat) - 2);
        check({tag, " latency"},  lat, elat);
        check({tag, " busy"},     busy_seen, busy_exp);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " dbz"},      div_by_zero, edbz);
    endtask

    initial begin
        int done_cnt;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        tick();
        tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset q",    quotient, 0);
        check("reset r",    remainder, 0);
        check("reset dbz",  div_by_zero, 0);
        rst_n = 1'b1;

        run_div("13/3",  4'd13, 4'd3, 4'd4,  4'd1, 1'b0, 5, 1'b0);
        run_div("15/1",  4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5, 1'b0);
        run_div("0/7",   4'd0,  4'd7, 4'd0,  4'd0, 1'b0, 5, 1'b0);
        run_div("5/9",   4'd5,  4'd9, 4'd0,  4'd5, 1'b0, 5, 1'b0);
        run_div("7/0",   4'd7,  4'd0, 4'd15, 4'd7, 1'b1, 1, 1'b0);
        run_div("6/2",   4'd6,  4'd2, 4'd3,  4'd0, 1'b0, 5, 1'b0);
        run_div("9/2 inj", 4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 5, 1'b1);

        // Reset in the middle of 12/5.
        tick();
        dividend = 4'd12;
        divisor  = 4'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("12/5 busy before reset", busy, 1);
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst q",    quotient, 0);
        check("midrst r",    remainder, 0);
        check("midrst dbz",  div_by_zero, 0);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (done) done_cnt++;
            if (busy) done_cnt += 16;
        end
        check("midrst no done/busy after", done_cnt, 0);
        run_div("12/5",  4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 5, 1'b0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0)
                    run_div($sformatf("ex %0d/%0d", a, b), 4'(a), 4'(b), 4'd15, 4'(a), 1'b1, 1, 1'b0);
                else
                    run_div($sformatf("ex %0d/%0d", a, b), 4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, 5, 1'b0);
            end
        end
        tick();
        check("final done pulse ends", done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
